// File: rtl/sdpb_fifo_ctrl_if.sv
// Stream handshake bundle for sdpb_fifo_ctrl.
// Producer side: s_data, s_valid and s_ready. A word transfers when s_valid && s_ready.
// Consumer side: m_data, m_valid and m_ready. A word transfers when m_valid && m_ready.
// master : the environment, which drives the producer data and m_ready.
// slave  : the FIFO controller, which drives s_ready, m_data and m_valid.
interface sdpb_fifo_ctrl_if #(
   parameter int unsigned DW = 32
) ();
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid
   );

   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid
   );
endinterface

// File: rtl/sdpb_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 2^AW x DW simple-dual-port block RAM
// (bypass read mode, 1-cycle read latency). A 2-entry output buffer hides the RAM latency.
// Ports:
//   clk, rst_n     clock (also RAM clka/clkb), asynchronous active-low reset
//   flush          synchronous clear of pointers, counts and flags
//   bus (slave)    s_data/s_valid/s_ready write stream, m_data/m_valid/m_ready read stream
//   level          words accepted and not yet popped (0..DEPTH+2)
//   almost_full    registered, level >= AFULL_TH
//   ovf            sticky, set by s_valid while s_ready is low
//   ram_*          RAM port A (write) / port B (read) controls; ram_dout is the RAM read data
module sdpb_fifo_ctrl #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 12,
   parameter int unsigned AFULL_TH = 4032
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   sdpb_fifo_ctrl_if.slave bus,
   output logic [AW:0]    level,
   output logic           almost_full,
   output logic           ovf,
   output logic [AW-1:0]  ram_ada,
   output logic [DW-1:0]  ram_din,
   output logic           ram_cea,
   output logic [AW-1:0]  ram_adb,
   output logic           ram_ceb,
   output logic           ram_oce,
   output logic           ram_reset,
   input  logic [DW-1:0]  ram_dout
);

   localparam logic [AW:0] DepthW  = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AfullTh = (AW + 1)'(AFULL_TH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   ram_used_q, ram_used_d;
   logic          inflight_q, inflight_d;
   logic [DW-1:0] obuf0_q, obuf0_d;  // head of the FIFO
   logic [DW-1:0] obuf1_q, obuf1_d;
   logic [1:0]    obuf_cnt_q, obuf_cnt_d;
   logic          ovf_q, ovf_d;
   logic          afull_q, afull_d;

   logic          s_ready;
   logic          m_valid;
   logic          accept;
   logic          pop;
   logic          rd_issue;
   logic [2:0]    occ;

   always_comb begin
      s_ready  = (ram_used_q != DepthW) && !flush;
      m_valid  = (obuf_cnt_q != 2'd0);
      accept   = bus.s_valid && s_ready;
      pop      = m_valid && bus.m_ready;
      // Output-side occupancy: buffered words plus the word arriving from the RAM.
      occ      = {1'b0, obuf_cnt_q} + {2'b00, inflight_q};
      // A pop in this cycle frees a slot, so the refill read can go out at the same edge.
      rd_issue = (ram_used_q != '0) && ((occ - {2'b00, pop}) < 3'd2) && !flush;
      level    = ram_used_q + (AW + 1)'(inflight_q) + (AW + 1)'(obuf_cnt_q);
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_data  = obuf0_q;
   assign almost_full = afull_q;
   assign ovf         = ovf_q;

   assign ram_ada   = wr_ptr_q;
   assign ram_din   = bus.s_data;
   assign ram_cea   = accept;
   assign ram_adb   = rd_ptr_q;
   assign ram_ceb   = rd_issue;
   assign ram_oce   = 1'b1;
   assign ram_reset = 1'b0;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ram_used_d = ram_used_q;
      inflight_d = rd_issue;
      obuf0_d    = obuf0_q;
      obuf1_d    = obuf1_q;
      obuf_cnt_d = obuf_cnt_q;
      ovf_d      = ovf_q | (bus.s_valid && !s_ready);
      afull_d    = (level >= AfullTh);

      if (accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_issue) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({accept, rd_issue})
         2'b10:   ram_used_d = ram_used_q + 1'b1;
         2'b01:   ram_used_d = ram_used_q - 1'b1;
         default: ram_used_d = ram_used_q;
      endcase

      // Pop shifts the head out first, then the captured RAM word lands behind what remains.
      case ({pop, inflight_q})
         2'b10: begin
            obuf0_d    = obuf1_q;
            obuf_cnt_d = obuf_cnt_q - 1'b1;
         end
         2'b01: begin
            if (obuf_cnt_q == 2'd0) begin
               obuf0_d = ram_dout;
            end else begin
               obuf1_d = ram_dout;
            end
            obuf_cnt_d = obuf_cnt_q + 1'b1;
         end
         2'b11: begin
            if (obuf_cnt_q == 2'd1) begin
               obuf0_d = ram_dout;
            end else begin
               obuf0_d = obuf1_q;
               obuf1_d = ram_dout;
            end
         end
         default: ;
      endcase

      // Flush drops everything, including a word still coming out of the RAM.
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ram_used_d = '0;
         inflight_d = 1'b0;
         obuf_cnt_d = 2'd0;
         ovf_d      = 1'b0;
         afull_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_used_q <= '0;
         inflight_q <= 1'b0;
         obuf0_q    <= '0;
         obuf1_q    <= '0;
         obuf_cnt_q <= 2'd0;
         ovf_q      <= 1'b0;
         afull_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_used_q <= ram_used_d;
         inflight_q <= inflight_d;
         obuf0_q    <= obuf0_d;
         obuf1_q    <= obuf1_d;
         obuf_cnt_q <= obuf_cnt_d;
         ovf_q      <= ovf_d;
         afull_q    <= afull_d;
      end
   end

endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// Self-checking bench for sdpb_fifo_ctrl with a behavioural 4096 x 32 SDPB RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sdpb_fifo_ctrl;
   localparam int DW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [AW:0]   level;
   logic          almost_full;
   logic          ovf;
   logic [AW-1:0] ram_ada;
   logic [DW-1:0] ram_din;
   logic          ram_cea;
   logic [AW-1:0] ram_adb;
   logic          ram_ceb;
   logic          ram_oce;
   logic          ram_reset;
   logic [DW-1:0] ram_dout = '0;

   sdpb_fifo_ctrl_if #(.DW(DW)) bus ();

   sdpb_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_TH(4032)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .level       (level),
      .almost_full (almost_full),
      .ovf         (ovf),
      .ram_ada     (ram_ada),
      .ram_din     (ram_din),
      .ram_cea     (ram_cea),
      .ram_adb     (ram_adb),
      .ram_ceb     (ram_ceb),
      .ram_oce     (ram_oce),
      .ram_reset   (ram_reset),
      .ram_dout    (ram_dout)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:4095];
   always @(posedge clk) begin
      if (ram_cea) mem[ram_ada] <= ram_din;
      if (ram_ceb) ram_dout <= mem[ram_adb];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] FillBase = 32'h1000_0000;
   localparam logic [31:0] StrmBase = 32'h2000_0000;

   initial begin
      int cnt;
      int popped;
      int sent;
      int got;
      int viol;
      bit done;
      bit af_next;
      logic [31:0] q [$];

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_level", level, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_ovf", ovf, 0);
      check("rst_afull", almost_full, 0);
      check("rst_oce", ram_oce, 1);
      check("rst_ram_reset", ram_reset, 0);
      rst_n = 1'b1;

      // Ten back-to-back writes, then ten pops
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'd1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t1_level", level, k + 1);
         if (k < 4) check("t1_latency", bus.m_valid, (k >= 2));
         if (k < 9) bus.s_data = 32'(k + 2);
         else bus.s_valid = 1'b0;
      end
      @(negedge clk);
      check("t1_level10", level, 10);
      check("t1_head", bus.m_data, 32'd1);
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         check("t1_pop_valid", bus.m_valid, 1);
         check("t1_pop_data", bus.m_data, i);
         @(negedge clk);
      end
      check("t1_empty_valid", bus.m_valid, 0);
      check("t1_empty_level", level, 0);
      bus.m_ready = 1'b0;

      // Fill to full, almost_full lag, overflow
      cnt = 0;
      done = 1'b0;
      af_next = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
         @(negedge clk);
         if (af_next) begin
            check("t2_afull_set", almost_full, 1);
            af_next = 1'b0;
         end
         if (level == 13'd4032) begin
            check("t2_afull_lag", almost_full, 0);
            af_next = 1'b1;
         end
         bus.s_valid = 1'b1;
         bus.s_data  = FillBase + 32'(cnt);
         if (bus.s_ready) cnt++;
         else done = 1'b1;
      end
      check("t2_accepts", cnt, 4098);
      check("t2_level_full", level, 4098);
      check("t2_afull_full", almost_full, 1);
      check("t2_ovf_before", ovf, 0);
      @(negedge clk);
      check("t2_ovf_set", ovf, 1);
      check("t2_s_ready_low", bus.s_ready, 0);
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      popped = 0;
      for (int c = 0; c < 5000 && popped < 4098; c++) begin
         if (c == 1) check("t2_s_ready_back", bus.s_ready, 1);
         if (bus.m_valid) begin
            check("t2_drain_data", bus.m_data, FillBase + 32'(popped));
            popped++;
         end
         @(negedge clk);
      end
      check("t2_drained", popped, 4098);
      check("t2_drain_level", level, 0);
      check("t2_drain_valid", bus.m_valid, 0);
      check("t2_ovf_sticky", ovf, 1);
      bus.m_ready = 1'b0;

      // Simultaneous push and pop every cycle from empty
      sent = 0;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = StrmBase + 32'(sent);
         bus.m_ready = 1'b1;
         check("t4_s_ready", bus.s_ready, 1);
         sent++;
         if (c >= 3) begin
            check("t4_m_valid", bus.m_valid, 1);
            check("t4_level_steady", (level == 13'd2) || (level == 13'd3), 1);
         end
         if (bus.m_valid) begin
            check("t4_data", bus.m_data, StrmBase + 32'(got));
            got++;
         end
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.m_valid) begin
            check("t4_tail_data", bus.m_data, StrmBase + 32'(got));
            got++;
         end
         @(negedge clk);
      end
      check("t4_count", got, sent);
      check("t4_level_end", level, 0);
      bus.m_ready = 1'b0;

      // Flush with level 100 and a read in flight
      for (int i = 0; i < 101; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'hA000_0000 + 32'(i);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_level101", level, 101);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      check("t5_level100", level, 100);
      check("t5_inflight", dut.inflight_q, 1);
      flush = 1'b1;
      #1;
      check("t5_flush_s_ready", bus.s_ready, 0);
      check("t5_flush_ceb", ram_ceb, 0);
      @(negedge clk);
      flush = 1'b0;
      check("t5_level0", level, 0);
      check("t5_m_valid0", bus.m_valid, 0);
      check("t5_ovf0", ovf, 0);
      check("t5_afull0", almost_full, 0);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_new_valid", bus.m_valid, 1);
      check("t5_new_data", bus.m_data, 32'hDEAD_BEEF);
      check("t5_new_level", level, 1);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      check("t5_after_level", level, 0);
      check("t5_after_valid", bus.m_valid, 0);

      // Random traffic against a queue scoreboard
      viol = 0;
      for (int c = 0; c < 20000; c++) begin
         check("rnd_level", level, q.size());
         if (dut.obuf_cnt_q + dut.inflight_q > 2) viol++;
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_data  = $urandom;
         bus.m_ready = 1'($urandom_range(0, 1));
         #1;
         if (bus.m_valid && bus.m_ready) begin
            check("rnd_pop_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) check("rnd_data", bus.m_data, q.pop_front());
         end
         if (bus.s_valid && bus.s_ready) q.push_back(bus.s_data);
         @(negedge clk);
      end
      check("rnd_invariant", viol, 0);

      // Asynchronous reset mid-burst
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h5000_0000 + 32'(i);
         @(negedge clk);
      end
      #2;
      rst_n = 1'b0;
      bus.s_valid = 1'b0;
      #1;
      check("t6_level", level, 0);
      check("t6_m_valid", bus.m_valid, 0);
      check("t6_afull", almost_full, 0);
      check("t6_ovf", ovf, 0);
      check("t6_cea", ram_cea, 0);
      check("t6_ceb", ram_ceb, 0);
      check("t6_s_ready", bus.s_ready, 1);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h1234_5678;
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_post_valid", bus.m_valid, 1);
      check("t6_post_data", bus.m_data, 32'h1234_5678);
      check("t6_post_level", level, 1);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      check("t6_post_empty", bus.m_valid, 0);
      check("t6_post_level0", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sdpb_fifo_ctrl.md
# sdpb_fifo_ctrl

Streaming FIFO controller that turns the 4096 x 32 simple-dual-port block RAM (Gowin_SDPB, bypass read mode) into a first-word-fall-through sample buffer. It sits between a DSP producer stage and a consumer stage on one clock domain. It drives the RAM's write and read ports from valid/ready handshakes and hides the RAM's 1-cycle read latency with a 2-entry output buffer. It reports fill level, almost-full and a sticky overflow flag.

## Interface
- DW, 32, data width; matches RAM din/dout.
- AW, 12, RAM address width; DEPTH = 2^AW = 4096.
- AFULL_TH, 4032, almost_full asserts when level >= AFULL_TH.
- clk  in  1  clock; also drives RAM clka and clkb.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all contents and flags.
- s_data  in  DW  write data.
- s_valid  in  1  write request.
- s_ready  out  1  write accepted when s_valid && s_ready.
- m_data  out  DW  read data (head of FIFO).
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer pops when m_valid && m_ready.
- level  out  AW+1  words accepted and not yet popped (0..DEPTH+2).
- almost_full  out  1  registered, level >= AFULL_TH.
- ovf  out  1  sticky: s_valid seen while s_ready low.
- ram_ada  out  AW  write address.
- ram_din  out  DW  write data (= s_data).
- ram_cea  out  1  write enable.
- ram_adb  out  AW  read address.
- ram_ceb  out  1  read enable.
- ram_oce  out  1  tied 1.
- ram_reset  out  1  tied 0.
- ram_dout  in  DW  RAM read data, valid the cycle after ram_ceb is sampled.

## Operation
- State: wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0 naturally); ram_used (AW+1 bits, 0..DEPTH); inflight (1 bit); obuf (2 entries, obuf_cnt 0..2); ovf; almost_full.
- Write: s_ready = (ram_used != DEPTH) && !flush. ram_cea = s_valid && s_ready; ram_ada = wr_ptr; ram_din = s_data. On accept, wr_ptr += 1.
- Read issue: rd_issue = (ram_used != 0) && (obuf_cnt + inflight - pop < 2) && !flush, with pop = m_valid && m_ready. ram_ceb = rd_issue; ram_adb = rd_ptr. On issue, rd_ptr += 1 and inflight <= 1, else inflight <= 0.
- ram_used next = ram_used + accept - rd_issue. Both in the same cycle leave it unchanged. The registered ram_used gates rd_issue, so a word is never read in the cycle it is written, and no same-address collision occurs.
- Capture: if inflight, ram_dout is pushed into obuf in that cycle.
- Output: m_valid = obuf_cnt != 0; m_data = obuf head. Pop and capture in the same cycle are both honoured in order. Invariant: obuf_cnt + inflight <= 2.
- level = ram_used + inflight + obuf_cnt, combinational from registers.
- ovf: set when s_valid && !s_ready && !flush. Cleared only by reset or flush.
- flush: at the next edge, pointers, ram_used, inflight, obuf_cnt, ovf and almost_full all go to 0. Any in-flight ram_dout is discarded. Handshakes in the flush cycle are ignored because s_ready and ram_ceb are forced low. RAM contents are not cleared.
- Reset (rst_n low, any time, including mid-transfer): all registers go to 0 asynchronously. Resulting outputs: s_ready = 1 after release, m_valid = 0, level = 0, almost_full = 0, ovf = 0, ram_cea = ram_ceb = 0.

## Timing
- First-word latency: write accepted at edge t, RAM read issued at edge t+1, data captured at edge t+2. m_valid is high after edge t+2 (2 cycles).
- Throughput: 1 word/cycle in each direction sustained, including simultaneous push and pop when level is steady.
- Pop at edge t frees an obuf slot. The refill read may be issued at the same edge, so the replacement word is captured at edge t+1.
- Full: ram_used == DEPTH drops s_ready combinationally. s_ready returns 1 cycle after the first read issue.
- almost_full is registered, so it lags level by 1 cycle.
- ram_cea, ram_ceb, ram_ada and ram_adb are combinational from registers plus s_valid/m_ready. No combinational path exists from ram_dout to any output.

## Test plan
- Reset then write 0x00000001..0x0000000A back-to-back with m_ready = 0 -> level = 10 and m_valid = 1 two cycles after the first accept; then m_ready = 1 -> m_data pops 0x1..0xA in order, one per cycle; m_valid = 0 afterwards; level = 0.
- Fill with s_valid held high and m_ready = 0 -> s_ready drops after 4096 RAM accepts. level = 4098 (RAM plus obuf). almost_full = 1 from level 4032 (+1 cycle). A further s_valid sets ovf = 1. Drain all 4098 -> data is an incrementing pattern with no gap or duplicate.
- Continuous random s_valid and m_ready at 50% for 20000 cycles, pointers wrapping several times -> scoreboard matches; obuf_cnt + inflight never exceeds 2; no pop while m_valid = 0.
- s_valid = m_ready = 1 every cycle from empty -> after a 2-cycle fill, one pop per cycle with level constant at 2 or 3.
- Assert flush with level = 100 and a read in flight -> the next cycle shows level = 0, m_valid = 0, ovf = 0; the stale ram_dout is not delivered; a subsequent write of 0xDEADBEEF is the first word popped.
- Pulse rst_n low mid-burst, asynchronous to clk -> all outputs reach their reset values immediately; after release, a write/read of 0x12345678 works normally.
